// File: rtl/uart_tx_frame_gen.sv
// UART frame serialiser: start, DATA_WIDTH bits LSB first, optional parity, stop (UART_TX_STOP2_EN adds a 2nd stop bit).
// Latency: start bit appears on TX_OUT right after the edge that accepts Data_Valid; one bit per CLK.
// Backpressure: Busy high for the whole frame; requests seen while Busy=1 are dropped, not queued.
module uart_tx_frame_gen #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`ifdef UART_TX_STOP2_EN
  input  logic                  STOP2,
`endif
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic [CW-1:0]         cnt_q, cnt_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_bit_q, par_bit_nxt;
  logic                  tx_nxt, busy_nxt;
`ifdef UART_TX_STOP2_EN
  logic                  stop2_q, stop2_nxt;
  logic                  stop_ext_q, stop_ext_nxt;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are registered from the next-state decode so TX_OUT never glitches.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop2_q    <= 1'b0;
      stop_ext_q <= 1'b0;
`endif
    end else begin
      shift_q    <= shift_nxt;
      cnt_q      <= cnt_nxt;
      par_en_q   <= par_en_nxt;
      par_bit_q  <= par_bit_nxt;
      TX_OUT     <= tx_nxt;
      Busy       <= busy_nxt;
`ifdef UART_TX_STOP2_EN
      stop2_q    <= stop2_nxt;
      stop_ext_q <= stop_ext_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_q;
    cnt_nxt      = cnt_q;
    par_en_nxt   = par_en_q;
    par_bit_nxt  = par_bit_q;
    tx_nxt       = 1'b1;
    busy_nxt     = 1'b1;
`ifdef UART_TX_STOP2_EN
    stop2_nxt    = stop2_q;
    stop_ext_nxt = stop_ext_q;
`endif
    unique case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (Data_Valid) begin
          // Parity is fixed at acceptance so later input changes cannot leak in.
          shift_nxt   = P_DATA;
          par_en_nxt  = PAR_EN;
          par_bit_nxt = (^P_DATA) ^ PAR_TYP;
          cnt_nxt     = '0;
`ifdef UART_TX_STOP2_EN
          stop2_nxt    = STOP2;
          stop_ext_nxt = 1'b0;
`endif
          state_nxt   = START;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
        end
      end
      START: begin
        state_nxt = DATA;
        tx_nxt    = shift_q[0];
        shift_nxt = shift_q >> 1;
        cnt_nxt   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_nxt = '0;
          if (par_en_q) begin
            state_nxt = PARITY;
            tx_nxt    = par_bit_q;
          end else begin
            state_nxt = STOP;
          end
        end else begin
          tx_nxt    = shift_q[0];
          shift_nxt = shift_q >> 1;
          cnt_nxt   = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        state_nxt = STOP;
      end
      STOP: begin
`ifdef UART_TX_STOP2_EN
        if (stop2_q && !stop_ext_q) begin
          stop_ext_nxt = 1'b1;
        end else begin
          stop_ext_nxt = 1'b0;
          state_nxt    = IDLE;
          busy_nxt     = 1'b0;
        end
`else
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
`endif
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
